mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
//
// PURPOSE
//  Shares one 8x8 unsigned multiplier between NUM_REQ requesters.
//  Round-robin arbitration with a valid/ready request handshake and a pipelined multiply.
//  Accepts at most one operation per cycle.
//  Returns each 16-bit product to its requester, tagged by index, after a fixed latency.
//  Sits between the requesting datapath blocks and the multiply resource.
//
// PARAMETERS
//  NUM_REQ  4  number of requesters, >= 2
//  LATENCY  2  cycles from accept to result, >= 1
//
// PORTS
//  clk        in   1                single clock, rising edge
//  rst_n      in   1                asynchronous reset, active-low
//  req_valid  in   NUM_REQ          requester i has operands ready
//  req_a      in   NUM_REQ x 8      operand A per requester, unsigned
//  req_b      in   NUM_REQ x 8      operand B per requester, unsigned
//  req_ready  out  NUM_REQ          one-hot or zero grant; accept = valid & ready
//  hold       in   1                1 = accept no new operations
//  res_valid  out  NUM_REQ          one-hot 1-cycle strobe: result for requester i
//  res_data   out  16               product A*B
//  res_id     out  $clog2(NUM_REQ)  index of requester owning res_data
//  busy       out  1                1 = at least one operation in flight
//
// BEHAVIOUR
//  - Reset (rst_n=0, takes effect immediately, independent of clk):
//    - res_valid=0, res_data=0, res_id=0, busy=0.
//    - Round-robin pointer ptr=0; all pipeline valid bits cleared.
//    - req_ready=0 while rst_n=0.
//  - Arbitration (combinational, every cycle):
//    - If hold=0, grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
//    - req_ready[g]=1; all other bits 0. No valid request, or hold=1, gives req_ready=0.
//  - Accept at a rising edge when req_valid[g] & req_ready[g]:
//    - A/B of g are captured; ptr <= (g+1) mod NUM_REQ.
//    - No accept leaves ptr unchanged.
//  - Arithmetic: unsigned 8x8 -> 16 bit, full precision, never overflows (max 255*255 = 0xFE01).
//  - Latency: operation accepted in cycle t gives res_valid[g]=1 for exactly cycle t+LATENCY.
//    - That cycle also carries res_data = product and res_id = g.
//  - Throughput 1/cycle; a requester may be granted back-to-back if it is the only one valid.
//  - No backpressure on results; requesters must sink res_valid when it occurs.
//  - res_data/res_id hold their last value while res_valid=0.
//  - busy = OR of the pipeline-stage valid bits (registered); 0 when pipeline is empty.
//  - hold=1 blocks new accepts only; in-flight operations complete and deliver normally.
//  - A requester may drop req_valid before grant; the request is simply never accepted.
//  - Reset mid-operation: all in-flight operations are discarded.
//    - No res_valid is produced for them after rst_n deasserts.
//    - ptr restarts at 0.
//
// STRUCTURE
//  - Package mul_share_pkg:
//    - OP_W=8, RES_W=16.
//    - typedef mul_op_t {logic [OP_W-1:0] a, b;}.
//    - typedef mul_res_t {logic [RES_W-1:0] data;}.
//  - Sub-module mul_pipe:
//    - LATENCY-stage registered multiplier, carries a valid bit and id tag per stage.
//    - Same clk/rst_n; resets only valid bits and outputs.
//  - Top level holds the round-robin arbiter, ptr register, operand mux and result fan-out.
//
// TESTING
//  1. req_valid=0001, A=12, B=13, hold=0 -> req_ready=0001 same cycle; 2 cycles later res_valid=0001, res_data=156, res_id=0.
//  2. Requester 3 with A=255, B=255 -> res_data=0xFE01, res_id=3, single-cycle strobe.
//  3. req_valid=1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; results on consecutive cycles in the same order, busy=1 throughout.
//  4. Grant to 2, then req_valid=1010 -> 3 granted before 1; ptr then 0 after grant 3, 2 after grant 1.
//  5. Two ops in flight, then hold=1 with req_valid=1111 -> req_ready=0000; both results still delivered; busy=0 one cycle after the last.
//  6. Two ops in flight, rst_n=0 for 1 cycle -> outputs 0 immediately, no res_valid after release; next req_valid=1111 granted 0 first.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Package: mul_share_pkg
// Shared widths, operand/result types and the product helper used by the
// multiplier-sharing arbiter and its pipeline.
package mul_share_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } mul_op_t;

    typedef struct packed {
        logic [RES_W-1:0] data;
    } mul_res_t;

    // Full-precision unsigned product; 8x8 always fits in 16 bits.
    function automatic mul_res_t mul_prod(input mul_op_t op);
        mul_res_t r;
        r.data = RES_W'(op.a) * RES_W'(op.b);
        return r;
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Module: mul_pipe
// LATENCY-stage registered unsigned multiplier. The product is formed on entry
// and then carried, with a valid bit and requester id, through the stages.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     operation entering this cycle
//   in_op        operands A/B
//   in_id        requester tag
//   out_valid    last-stage valid (one cycle per operation)
//   out_res      product; holds last delivered value while out_valid=0
//   out_id       tag of out_res; holds like out_res
//   busy         any stage holds a valid operation
module mul_pipe
    import mul_share_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  mul_op_t         in_op,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output mul_res_t        out_res,
    output logic [ID_W-1:0] out_id,
    output logic            busy
);

    logic [LATENCY-1:0] stage_vld;

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic            vld_in;
        mul_res_t        res_in;
        logic [ID_W-1:0] id_in;
        logic            vld_q;
        mul_res_t        res_q;
        logic [ID_W-1:0] id_q;

        if (s == 0) begin : g_first
            assign vld_in = in_valid;
            assign res_in = mul_prod(in_op);
            assign id_in  = in_id;
        end else begin : g_next
            assign vld_in = g_stage[s-1].vld_q;
            assign res_in = g_stage[s-1].res_q;
            assign id_in  = g_stage[s-1].id_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_in;
            end
        end

        // Payload only moves with a valid op, so the last stage naturally
        // holds the previously delivered result between strobes.
        if (s == LATENCY - 1) begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                    id_q  <= '0;
                end else if (vld_in) begin
                    res_q <= res_in;
                    id_q  <= id_in;
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (vld_in) begin
                    res_q <= res_in;
                    id_q  <= id_in;
                end
            end
        end

        assign stage_vld[s] = vld_q;
    end

    assign out_valid = g_stage[LATENCY-1].vld_q;
    assign out_res   = g_stage[LATENCY-1].res_q;
    assign out_id    = g_stage[LATENCY-1].id_q;
    assign busy      = |stage_vld;

endmodule

// File: rtl/mul_share_arbiter.sv
// Module: mul_share_arbiter
// Shares one pipelined 8x8 multiplier between NUM_REQ requesters using
// round-robin arbitration; at most one operation accepted per cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester operand-ready
//   req_a/req_b  per-requester operands
//   req_ready    one-hot (or zero) grant; accept = valid & ready
//   hold         block new accepts; in-flight ops still complete
//   res_valid    one-hot single-cycle result strobe
//   res_data     product of the owning requester
//   res_id       index of the owning requester
//   busy         at least one operation in flight
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][OP_W-1:0]        req_a,
    input  logic [NUM_REQ-1:0][OP_W-1:0]        req_b,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                hold,
    output logic [NUM_REQ-1:0]                  res_valid,
    output logic [RES_W-1:0]                    res_data,
    output logic [$clog2(NUM_REQ)-1:0]          res_id,
    output logic                                busy
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_found;
    logic            accept;
    mul_op_t         op;
    logic            pipe_valid;
    mul_res_t        pipe_res;
    logic [ID_W-1:0] pipe_id;

    // Search from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        req_ready = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        idx       = '0;
        if (rst_n && !hold) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                idx = ID_W'((int'(ptr_q) + k) % int'(NUM_REQ));
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found      = 1'b1;
                    gnt_id         = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    assign accept = gnt_found;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign op.a = req_a[gnt_id];
    assign op.b = req_b[gnt_id];

    mul_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) u_mul_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_op     (op),
        .in_id     (gnt_id),
        .out_valid (pipe_valid),
        .out_res   (pipe_res),
        .out_id    (pipe_id),
        .busy      (busy)
    );

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            res_valid[i] = pipe_valid && (pipe_id == ID_W'(i));
        end
    end

    assign res_data = pipe_res.data;
    assign res_id   = pipe_id;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_a;
    logic [3:0][7:0] req_b;
    logic [3:0]      req_ready;
    logic            hold;
    logic [3:0]      res_valid;
    logic [15:0]     res_data;
    logic [1:0]      res_id;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Products for operands a=10+i, b=3+i.
    logic [15:0] exp_prod [4] = '{16'd30, 16'd44, 16'd60, 16'd78};

    mul_share_arbiter #(
        .NUM_REQ (4),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 8'(10 + i);
            req_b[i] = 8'(3 + i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; req_valid = 4'b1111; set_default_ops();
        #3;
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL reset_res_valid got=%b exp=0000", res_valid); end
        checks++; if (res_data !== 16'd0) begin errors++; $display("FAIL reset_res_data got=%h exp=0000", res_data); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_valid = 4'b0001; req_a[0] = 8'd12; req_b[0] = 8'd13;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t1_early_res got=%b exp=0000", res_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy1 got=%b exp=1", busy); end
        step(); #1;
        checks++; if (res_valid !== 4'b0001) begin errors++; $display("FAIL t1_res_valid got=%b exp=0001", res_valid); end
        checks++; if (res_data !== 16'd156) begin errors++; $display("FAIL t1_res_data got=%0d exp=156", res_data); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL t1_res_id got=%0d exp=0", res_id); end
        step(); #1;
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t1_strobe_len got=%b exp=0000", res_valid); end
        checks++; if (res_data !== 16'd156) begin errors++; $display("FAIL t1_data_hold got=%0d exp=156", res_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_idle got=%b exp=0", busy); end
    endtask

    // ptr is 1 here; requester 3 alone must still be found by the wrap search.
    task automatic test_max_operands();
        req_valid = 4'b1000; req_a[3] = 8'd255; req_b[3] = 8'd255;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t2_ready got=%b exp=1000", req_ready); end
        step();
        req_valid = 4'b0000;
        step(); #1;
        checks++; if (res_valid !== 4'b1000) begin errors++; $display("FAIL t2_res_valid got=%b exp=1000", res_valid); end
        checks++; if (res_data !== 16'hFE01) begin errors++; $display("FAIL t2_res_data got=%h exp=fe01", res_data); end
        checks++; if (res_id !== 2'd3) begin errors++; $display("FAIL t2_res_id got=%0d exp=3", res_id); end
        step(); #1;
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t2_strobe_len got=%b exp=0000", res_valid); end
        set_default_ops();
    endtask

    // ptr is 0 here.
    task automatic test_round_robin_all();
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        for (int c = 0; c < 11; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL t3_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            if (c >= 2 && c < 10) begin
                exp_rv = 4'(1 << ((c - 2) % 4));
                checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL t3_res_valid c=%0d got=%b exp=%b", c, res_valid, exp_rv); end
                checks++; if (res_data !== exp_prod[(c - 2) % 4]) begin errors++; $display("FAIL t3_res_data c=%0d got=%0d exp=%0d", c, res_data, exp_prod[(c - 2) % 4]); end
                checks++; if (res_id !== 2'((c - 2) % 4)) begin errors++; $display("FAIL t3_res_id c=%0d got=%0d exp=%0d", c, res_id, (c - 2) % 4); end
            end
            if (c >= 1 && c < 10) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t3_busy c=%0d got=%b exp=1", c, busy); end
            end
            if (c == 10) begin
                checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t3_res_done got=%b exp=0000", res_valid); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy_done got=%b exp=0", busy); end
            end
            step();
        end
    endtask

    // ptr is 0 here. Grants: 2, then 3 before 1, then ptr=2 shown by 1111 -> 2.
    task automatic test_wrap_priority();
        logic [3:0] vec   [6] = '{4'b0100, 4'b1010, 4'b0010, 4'b1111, 4'b0000, 4'b0000};
        logic [3:0] rdy   [6] = '{4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
        int         gid   [6] = '{2, 3, 1, 2, -1, -1};
        for (int c = 0; c < 6; c++) begin
            req_valid = vec[c];
            #1;
            checks++; if (req_ready !== rdy[c]) begin errors++; $display("FAIL t4_ready c=%0d got=%b exp=%b", c, req_ready, rdy[c]); end
            if (c >= 2) begin
                checks++; if (res_valid !== 4'(1 << gid[c - 2])) begin errors++; $display("FAIL t4_res_valid c=%0d got=%b exp=%b", c, res_valid, 4'(1 << gid[c - 2])); end
                checks++; if (res_id !== 2'(gid[c - 2])) begin errors++; $display("FAIL t4_res_id c=%0d got=%0d exp=%0d", c, res_id, gid[c - 2]); end
                checks++; if (res_data !== exp_prod[gid[c - 2]]) begin errors++; $display("FAIL t4_res_data c=%0d got=%0d exp=%0d", c, res_data, exp_prod[gid[c - 2]]); end
            end
            step();
        end
    endtask

    // ptr is 3 here: two accepts (3 then 0), then hold blocks further grants.
    task automatic test_hold();
        req_valid = 4'b1111; #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t5_ready0 got=%b exp=1000", req_ready); end
        step(); #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t5_ready1 got=%b exp=0001", req_ready); end
        step();
        hold = 1'b1; #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t5_hold_ready got=%b exp=0000", req_ready); end
        checks++; if (res_valid !== 4'b1000 || res_data !== 16'd78) begin errors++; $display("FAIL t5_res_a got=%b/%0d exp=1000/78", res_valid, res_data); end
        step(); #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t5_hold_ready2 got=%b exp=0000", req_ready); end
        checks++; if (res_valid !== 4'b0001 || res_data !== 16'd30) begin errors++; $display("FAIL t5_res_b got=%b/%0d exp=0001/30", res_valid, res_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_last got=%b exp=1", busy); end
        step(); #1;
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t5_res_none got=%b exp=0000", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_after got=%b exp=0", busy); end
        hold = 1'b0; req_valid = 4'b0000;
        step();
    endtask

    // ptr is 1 here: grants 1 and 2 in flight, then reset discards both.
    task automatic test_reset_midflight();
        req_valid = 4'b1111; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t6_ready0 got=%b exp=0010", req_ready); end
        step(); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL t6_ready1 got=%b exp=0100", req_ready); end
        step();
        rst_n = 1'b0; #1;
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t6_rst_res_valid got=%b exp=0000", res_valid); end
        checks++; if (res_data !== 16'd0 || res_id !== 2'd0) begin errors++; $display("FAIL t6_rst_res got=%0d/%0d exp=0/0", res_data, res_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_rst_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t6_rst_ready got=%b exp=0000", req_ready); end
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL t6_ghost c=%0d got=%b exp=0000", c, res_valid); end
            step();
        end
        req_valid = 4'b1111; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t6_ptr_restart got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_operands();
        test_round_robin_all();
        test_wrap_priority();
        test_hold();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
